// File: rtl/rv32i_types.sv
// Shared RV32I front-end types: predictor direction encoding and branch tracking entry.
package rv32i_types;

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        no_take = 1'b0,
        take    = 1'b1
    } prediction_choice;

    typedef struct packed {
        logic             valid;
        logic [XLEN-1:0]  pc;
        prediction_choice pred;
    } br_track_t;

    localparam logic [XLEN-1:0] BR_PC_INC = 32'd4;

    // Fall-through fetch address; wraps naturally at 2^32.
    function automatic logic [XLEN-1:0] br_fallthrough(input logic [XLEN-1:0] pc);
        return pc + BR_PC_INC;
    endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter with enable, async active-low clear, saturating at all-ones.
module sat_counter32
    import rv32i_types::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    output logic [XLEN-1:0] o_count
);

    logic [XLEN-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + XLEN'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_resolve_unit.sv
// Tracks IF branches through ID/EX, resolves direction in EX, flags mispredicts
// and produces the redirect PC, predictor update strobe and branch statistics.
module branch_resolve_unit
    import rv32i_types::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             pipeline_en,
    input  logic [XLEN-1:0]  if_pc,
    input  logic             if_is_br,
    input  prediction_choice if_prediction,
    input  logic             ex_br_en,
    input  logic [XLEN-1:0]  ex_target,
    output logic             ex_is_br,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             result,
    output logic             upd_valid,
    output logic [XLEN-1:0]  br_count,
    output logic [XLEN-1:0]  mp_count
);

    br_track_t r_id;
    br_track_t r_ex;

    logic w_mispredict;
    logic w_br_cnt_en;
    logic w_mp_cnt_en;

    // Squash wins over capture: a mispredict clears both stages, dropping the IF branch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_id <= '0;
            r_ex <= '0;
        end else if (pipeline_en) begin
            if (w_mispredict) begin
                r_id.valid <= 1'b0;
                r_ex.valid <= 1'b0;
            end else begin
                r_id <= '{valid: if_is_br, pc: if_pc, pred: if_prediction};
                r_ex <= r_id;
            end
        end
    end

    // Resolution is combinational so the flush reaches IF/ID in the same cycle, even while stalled.
    always_comb begin
        w_mispredict = r_ex.valid & (ex_br_en != (r_ex.pred == take));
        redirect_pc  = '0;
        if (w_mispredict) begin
            redirect_pc = ex_br_en ? ex_target : br_fallthrough(r_ex.pc);
        end
    end

    assign ex_is_br    = r_ex.valid;
    assign mispredict  = w_mispredict;
    assign result      = ex_br_en & r_ex.valid;
    assign upd_valid   = r_ex.valid & pipeline_en;
    assign w_br_cnt_en = pipeline_en & r_ex.valid;
    assign w_mp_cnt_en = pipeline_en & w_mispredict;

    sat_counter32 u_br_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_br_cnt_en),
        .o_count (br_count)
    );

    sat_counter32 u_mp_cnt (
        .clk     (clk),
        .rst_n   (reset),
        .i_en    (w_mp_cnt_en),
        .o_count (mp_count)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: stimulus pushes expected outputs, a monitor compares.
module tb_branch_resolve_unit;
    import rv32i_types::*;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             pipeline_en = 1'b0;
    logic [31:0]      if_pc = '0;
    logic             if_is_br = 1'b0;
    prediction_choice if_prediction = no_take;
    logic             ex_br_en = 1'b0;
    logic [31:0]      ex_target = '0;
    logic             ex_is_br;
    logic             mispredict;
    logic [31:0]      redirect_pc;
    logic             result;
    logic             upd_valid;
    logic [31:0]      br_count;
    logic [31:0]      mp_count;

    branch_resolve_unit dut (
        .clk           (clk),
        .reset         (reset),
        .pipeline_en   (pipeline_en),
        .if_pc         (if_pc),
        .if_is_br      (if_is_br),
        .if_prediction (if_prediction),
        .ex_br_en      (ex_br_en),
        .ex_target     (ex_target),
        .ex_is_br      (ex_is_br),
        .mispredict    (mispredict),
        .redirect_pc   (redirect_pc),
        .result        (result),
        .upd_valid     (upd_valid),
        .br_count      (br_count),
        .mp_count      (mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        is_br;
        bit [31:0] pc;
        bit        pred_take;
    } instr_t;

    typedef struct {
        bit        ex_is_br;
        bit        mp;
        bit        result;
        bit        upd;
        bit [31:0] redirect;
        bit [31:0] br_cnt;
        bit [31:0] mp_cnt;
    } exp_t;

    exp_t      exp_q[$];
    instr_t    hist[$];   // instructions accepted on the last two enabled edges, oldest first
    bit [31:0] m_br = '0;
    bit [31:0] m_mp = '0;
    int        checks = 0;
    int        failures = 0;

    function automatic bit [31:0] sat_inc(input bit [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
        end
    endtask

    // One cycle: drive at negedge, push the expected outputs, then advance the model across the edge.
    task automatic step(input bit rst_n, input bit en, input bit br, input bit [31:0] pc,
                        input bit ptake, input bit taken, input bit [31:0] tgt, input bit preload);
        instr_t ex;
        instr_t bubble;
        instr_t cur;
        exp_t   e;
        bit     mp;
        bubble = '{is_br: 1'b0, pc: 32'h0, pred_take: 1'b0};
        @(negedge clk);
        reset         = rst_n;
        pipeline_en   = en;
        if_is_br      = br;
        if_pc         = pc;
        if_prediction = ptake ? take : no_take;
        ex_br_en      = taken;
        ex_target     = tgt;
        if (!rst_n) begin
            hist.delete();
            m_br = '0;
            m_mp = '0;
        end
        if (preload) begin
            force dut.u_mp_cnt.r_count = 32'hFFFF_FFFF;
            m_mp = 32'hFFFF_FFFF;
        end
        ex = (hist.size() == 2) ? hist[0] : bubble;
        mp = ex.is_br && (taken != ex.pred_take);
        e.ex_is_br = ex.is_br;
        e.mp       = mp;
        e.result   = ex.is_br && taken;
        e.upd      = ex.is_br && en;
        e.redirect = !mp ? 32'h0 : (taken ? tgt : ex.pc + 32'd4);
        e.br_cnt   = m_br;
        e.mp_cnt   = m_mp;
        exp_q.push_back(e);
        if (rst_n && en) begin
            if (ex.is_br) m_br = sat_inc(m_br);
            if (mp)       m_mp = sat_inc(m_mp);
            if (mp) begin
                foreach (hist[i]) hist[i].is_br = 1'b0;
                hist.push_back(bubble);
            end else begin
                cur = '{is_br: br, pc: pc, pred_take: ptake};
                hist.push_back(cur);
            end
            while (hist.size() > 2) void'(hist.pop_front());
        end
        if (preload) begin
            #1;
            release dut.u_mp_cnt.r_count;
        end
    endtask

    // Monitor: outputs are combinationally settled 2 time units after each negedge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("ex_is_br",    32'(ex_is_br),   32'(e.ex_is_br));
                chk("mispredict",  32'(mispredict), 32'(e.mp));
                chk("redirect_pc", redirect_pc,     e.redirect);
                chk("result",      32'(result),     32'(e.result));
                chk("upd_valid",   32'(upd_valid),  32'(e.upd));
                chk("br_count",    br_count,        e.br_cnt);
                chk("mp_count",    mp_count,        e.mp_cnt);
            end
        end
    end

    initial begin
        bit [31:0] rpc;
        bit [31:0] rtgt;
        int        waited;
        // reset state
        step(0, 1, 1, 32'h100, 0, 0, 32'h0, 0);
        step(1, 0, 0, 32'h0,   0, 0, 32'h0, 0);
        // correct not-taken
        step(1, 1, 1, 32'h100, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h104, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h108, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h10C, 0, 0, 32'h0, 0);
        // taken mispredict to 0x240
        step(1, 1, 1, 32'h200, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h204, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h208, 0, 1, 32'h240, 0);
        step(1, 1, 0, 32'h240, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h244, 0, 0, 32'h0, 0);
        // not-taken mispredict with fall-through wrap
        step(1, 1, 1, 32'hFFFF_FFFC, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h0,         0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h4,         0, 0, 32'h1234, 0);
        step(1, 1, 0, 32'h0,         0, 0, 32'h0, 0);
        // stall with a mispredicting branch in EX, then release
        step(1, 1, 1, 32'h500, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h504, 0, 0, 32'h0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 32'h508, 0, 1, 32'h600, 0);
        step(1, 1, 0, 32'h508, 0, 1, 32'h600, 0);
        step(1, 1, 0, 32'h600, 0, 0, 32'h0, 0);
        // squash priority over a new IF branch
        step(1, 1, 1, 32'h300, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h304, 0, 0, 32'h0, 0);
        step(1, 1, 1, 32'h400, 1, 0, 32'h0, 0);
        step(1, 1, 0, 32'h304, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h308, 0, 0, 32'h0, 0);
        // async reset with two valid entries in flight
        step(1, 1, 1, 32'h700, 0, 0, 32'h0, 0);
        step(1, 1, 1, 32'h704, 1, 0, 32'h0, 0);
        step(0, 1, 1, 32'h708, 0, 0, 32'h0, 0);
        step(0, 1, 0, 32'h70C, 0, 0, 32'h0, 0);
        step(1, 1, 1, 32'h800, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h804, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h808, 0, 0, 32'h0, 0);
        // mp_count saturation from a preloaded all-ones value
        step(1, 1, 1, 32'h900, 0, 0, 32'h0, 1);
        step(1, 1, 0, 32'h904, 0, 0, 32'h0, 0);
        step(1, 1, 0, 32'h908, 0, 1, 32'hA00, 0);
        step(1, 1, 0, 32'hA00, 0, 0, 32'h0, 0);
        // randomized traffic, with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            rpc  = $urandom();
            rtgt = $urandom();
            rpc[1:0] = 2'b00;
            if (i % 50 == 7) rpc = 32'hFFFF_FFFC;
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 6),
                 rpc, 1'($urandom()), 1'($urandom()), rtgt, 0);
        end
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        #5;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 The block SHALL have one clock and asynchronous active-low reset, with ports as follows: clk  input  1  rising-edge clock; reset  input  1  asynchronous active-low reset, asserted when 0.
REQ-002 pipeline_en  input  1  pipeline advance enable; 0 = stall, all state held.
REQ-003 if_pc  input  32  PC of the instruction currently in IF.
REQ-004 if_is_br  input  1  IF instruction is a conditional branch.
REQ-005 if_prediction  input  prediction_choice  predictor output for if_pc (no_take/take).
REQ-006 ex_br_en  input  1  resolved branch direction of the EX instruction, valid when ex_is_br=1.
REQ-007 ex_target  input  32  computed branch target of the EX instruction.
REQ-008 ex_is_br  output  1  EX stage holds a valid branch entry.
REQ-009 mispredict  output  1  EX branch direction differs from the predicted direction; flush IF/ID.
REQ-010 redirect_pc  output  32  fetch PC on mispredict: ex_target if actually taken, else EX pc+4.
REQ-011 result  output  1  resolved direction (1 = taken) for predictor update.
REQ-012 upd_valid  output  1  predictor update strobe; equals ex_is_br & pipeline_en.
REQ-013 br_count  output  32  resolved-branch counter.
REQ-014 mp_count  output  32  mispredict counter.

Function
REQ-015 The block SHALL hold a two-entry in-order tracking pipe, ID then EX, where each entry is {valid, pc, pred}.
REQ-016 On an enabled edge (pipeline_en=1) without mispredict: ID <= {if_is_br, if_pc, if_prediction}; EX <= ID.
REQ-017 On an enabled edge with mispredict=1: the ID and EX valid bits SHALL clear (wrong-path squash), and pc/pred are don't-care.
REQ-018 When pipeline_en=0, all entries and counters SHALL hold, and upd_valid=0.
REQ-019 Latency from IF to EX SHALL be exactly two enabled edges, and stalled cycles SHALL not count toward it.
REQ-020 ex_is_br SHALL equal EX.valid.
REQ-021 mispredict SHALL be combinational: ex_is_br & (ex_br_en != (EX.pred == take)).
REQ-022 mispredict SHALL be asserted during a stall as well, while flush and count effects take place only on an enabled edge.
REQ-023 redirect_pc SHALL be ex_target when ex_br_en=1, else EX.pc + 32'd4, with 32-bit wrap (32'hFFFFFFFC -> 32'h0).
REQ-024 redirect_pc SHALL be 32'h0 when mispredict=0.
REQ-025 result SHALL equal ex_br_en & ex_is_br.
REQ-026 br_count SHALL increment on each enabled edge with ex_is_br=1.
REQ-027 mp_count SHALL increment on each enabled edge with mispredict=1.
REQ-028 Both counters SHALL saturate at 32'hFFFFFFFF.
REQ-029 For simultaneous mispredict and a new IF branch, the squash SHALL take priority, so the IF branch is not captured into ID.
REQ-030 A non-branch in IF SHALL enter the pipe as valid=0 and produce no update, flush or count.

Reset
REQ-031 While reset=0, all valid bits, pc and pred fields, br_count and mp_count SHALL clear to 0/no_take immediately, independent of clk.
REQ-032 Reset values of outputs: ex_is_br=0, mispredict=0, redirect_pc=0, result=0, upd_valid=0, counters=0.
REQ-033 Reset asserted mid-operation SHALL discard in-flight entries with no update emitted.
REQ-034 The first enabled edge after reset deassertion SHALL load ID normally.

Structure
REQ-035 prediction_choice SHALL come from rv32i_types and is not redefined.
REQ-036 A packed struct br_track_t {valid, pc, pred} and the constant BR_PC_INC = 32'd4 SHALL be added to rv32i_types.
REQ-037 The block SHALL contain one sub-module, sat_counter32 (enable, saturating, async active-low clear), instantiated twice.
REQ-038 result/upd_valid SHALL connect to local_branch_predictor's result/is_br path; mispredict SHALL drive the IF/ID flush.

Verification
REQ-039 Correct not-taken: branch at if_pc=0x100, pred=no_take, two enabled edges, ex_br_en=0 -> ex_is_br=1, mispredict=0, upd_valid=1, result=0, br_count=1, mp_count=0.
REQ-040 Taken mispredict: pc=0x200, pred=no_take, ex_br_en=1, ex_target=0x240 -> mispredict=1, redirect_pc=0x240; next edge ID/EX valid=0 and mp_count=1.
REQ-041 Not-taken mispredict with wrap: pc=0xFFFFFFFC, pred=take, ex_br_en=0 -> redirect_pc=0x0.
REQ-042 Stall: hold pipeline_en=0 for 3 cycles with a branch in EX -> mispredict stays asserted, upd_valid=0, counters unchanged; release -> exactly one count.
REQ-043 Squash priority: mispredict in EX with if_is_br=1 on the same enabled edge -> following cycle ex_is_br=0 and no second update.
REQ-044 Async reset: drop reset between clock edges with two valid entries and counters=5 -> all outputs 0 before the next edge; preload mp_count=0xFFFFFFFF, mispredict -> stays 0xFFFFFFFF.
